// File: rtl/wide_arith_pkg.sv
// Shared types and defaults for the wide arithmetic datapath (adder/subtractor family).
package wide_arith_pkg;

  localparam int DEFAULT_WIDTH = 128;
  localparam int DEFAULT_LIMB  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } diff_state_e;

  // A single-limb configuration still needs a 1-bit index register.
  function automatic int limb_idx_width(input int nlimb);
    return (nlimb > 1) ? $clog2(nlimb) : 1;
  endfunction

endpackage

// File: rtl/limb_sub.sv
// One limb of ripple-borrow subtraction: {borrow_out, d} = s - a - borrow_in.
module limb_sub
  import wide_arith_pkg::*;
#(
  parameter int LIMB = DEFAULT_LIMB
) (
  input  logic [LIMB-1:0] s,
  input  logic [LIMB-1:0] a,
  input  logic            borrow_in,
  output logic [LIMB-1:0] d,
  output logic            borrow_out
);

  logic [LIMB:0] wide;

  // Zero-extending to LIMB+1 bits leaves the borrow in the top bit.
  always_comb begin
    wide       = {1'b0, s} - {1'b0, a} - {{LIMB{1'b0}}, borrow_in};
    d          = wide[LIMB-1:0];
    borrow_out = wide[LIMB];
  end

endmodule

// File: rtl/wide_diff_unit.sv
// Multi-cycle wide subtractor: diff = sum - addend, one limb per clock, LSB first.
// Optional simulation checker enabled by defining WIDE_DIFF_CHECK_EN.
module wide_diff_unit
  import wide_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LIMB  = DEFAULT_LIMB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] addend_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int IDXW  = limb_idx_width(NLIMB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NLIMB - 1);

  diff_state_e     state_q, state_d;
  logic [WIDTH-1:0] sum_q, addend_q, diff_q;
  logic [IDXW-1:0] idx_q;
  logic            carry_borrow_q;
  logic            borrow_q;

  logic [LIMB-1:0] s_limb, a_limb, d_limb;
  logic            b_next;
  logic            accept, last_limb;

  // Operand limbs are picked by the running index so a single limb_sub serves all limbs.
  always_comb begin
    s_limb = sum_q[int'(idx_q)*LIMB +: LIMB];
    a_limb = addend_q[int'(idx_q)*LIMB +: LIMB];
  end

  limb_sub #(.LIMB(LIMB)) u_limb_sub (
    .s          (s_limb),
    .a          (a_limb),
    .borrow_in  (carry_borrow_q),
    .d          (d_limb),
    .borrow_out (b_next)
  );

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready;
    last_limb = (idx_q == LAST_IDX);
    state_d   = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_limb) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers; diff/borrow hold until the next transaction's first CALC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q          <= '0;
      addend_q       <= '0;
      diff_q         <= '0;
      borrow_q       <= 1'b0;
      idx_q          <= '0;
      carry_borrow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sum_q          <= sum_i;
            addend_q       <= addend_i;
            idx_q          <= '0;
            carry_borrow_q <= 1'b0;
          end
        end
        CALC: begin
          diff_q[int'(idx_q)*LIMB +: LIMB] <= d_limb;
          carry_borrow_q                   <= b_next;
          if (last_limb) begin
            borrow_q <= b_next;
            idx_q    <= '0;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;

`ifdef WIDE_DIFF_CHECK_EN
  logic [WIDTH-1:0] chk_sum;
  assign chk_sum = diff_q + addend_q;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      assert (chk_sum == sum_q)
        else $error("wide_diff_unit: diff + addend != sum");
      assert (borrow_q == (addend_q > sum_q))
        else $error("wide_diff_unit: borrow does not match compare");
      $display("%0t wide_diff_unit: diff=%0d sum=%0d addend=%0d", $time, diff_q, sum_q, addend_q);
    end
  end
`endif

endmodule

// File: tb/tb_wide_diff_unit.sv
// Directed self-checking bench for wide_diff_unit with hand-computed expectations.
module tb_wide_diff_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] sum_i;
  logic [127:0] addend_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] diff_o;
  logic         borrow_o;

  int total = 0;
  int bad   = 0;

  wide_diff_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_i     (sum_i),
    .addend_i  (addend_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff_o    (diff_o),
    .borrow_o  (borrow_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one transaction and returns just after its acceptance edge.
  task automatic applyStimulus(input logic [127:0] s, input logic [127:0] a);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("in_ready_before_accept", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    sum_i    = s;
    addend_i = a;
    tick();
    in_valid = 1'b0;
    sum_i    = '0;
    addend_i = '0;
  endtask

  // Counts edges after acceptance until out_valid, then checks the result.
  task automatic waitResult(input string tag, input logic [127:0] exp_diff, input logic exp_borrow);
    int cycles = 0;
    checkOutput({tag, "_in_ready_busy"}, 128'(in_ready), 128'd0);
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput({tag, "_latency"}, 128'(cycles), 128'd4);
    checkOutput({tag, "_diff"}, diff_o, exp_diff);
    checkOutput({tag, "_borrow"}, 128'(borrow_o), 128'(exp_borrow));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_out_valid_after_hs"}, 128'(out_valid), 128'd0);
    checkOutput({tag, "_in_ready_after_hs"}, 128'(in_ready), 128'd1);
  endtask

  logic [127:0] exp_under;
  logic [127:0] held_diff;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_i     = '0;
    addend_i  = '0;
    tick();
    tick();
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_diff", diff_o, 128'd0);
    checkOutput("rst_borrow", 128'(borrow_o), 128'd0);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 128'(in_ready), 128'd1);

    applyStimulus(128'd25, 128'd10);
    waitResult("basic", 128'd15, 1'b0);
    handshake("basic");

    applyStimulus(128'd70, 128'd5);
    waitResult("second", 128'd65, 1'b0);
    checkOutput("second_in_ready_done", 128'(in_ready), 128'd0);
    handshake("second");

    applyStimulus(128'h1_0000_0000, 128'd1);
    waitResult("cross_limb", 128'h0000_0000_FFFF_FFFF, 1'b0);
    handshake("cross_limb");

    exp_under = 128'h0 - 128'd5;
    applyStimulus(128'd5, 128'd10);
    waitResult("underflow", exp_under, 1'b1);
    handshake("underflow");

    applyStimulus(128'd1000, 128'd1000);
    waitResult("equal", 128'd0, 1'b0);
    handshake("equal");

    // Backpressure: DONE held with out_ready low while a new request is offered.
    applyStimulus(128'd100, 128'd1);
    waitResult("bp", 128'd99, 1'b0);
    held_diff = diff_o;
    in_valid  = 1'b1;
    sum_i     = 128'd500;
    addend_i  = 128'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_out_valid_hold", 128'(out_valid), 128'd1);
      checkOutput("bp_diff_hold", diff_o, held_diff);
      checkOutput("bp_in_ready_low", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    tick();
    checkOutput("bp_no_new_accept", 128'(in_ready), 128'd1);
    checkOutput("bp_diff_after", diff_o, 128'd99);

    // Reset at the second CALC edge aborts the transaction.
    applyStimulus(128'd300, 128'd1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
    checkOutput("abort_diff", diff_o, 128'd0);
    checkOutput("abort_borrow", 128'(borrow_o), 128'd0);
    checkOutput("abort_in_ready", 128'(in_ready), 128'd0);
    rst = 1'b0;
    #1;
    checkOutput("abort_in_ready_release", 128'(in_ready), 128'd1);
    applyStimulus(128'd25, 128'd10);
    waitResult("after_abort", 128'd15, 1'b0);
    handshake("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
